// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - request/response initiator for a single-port registered-read memory with bulk init
module mem_initiator #(
    parameter int                ADDR_W     = 3,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 8,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'hCA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP,
        S_INIT
    } state_t;

    // One extra bit so the walking counter can hold DEPTH itself as the "all written" marker.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W:0]   cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n, rsp_addr_n;
    logic [DATA_W-1:0] wdata_n, rsp_rdata_n;
    logic              wr_en_n, rd_en_n;
    logic              rsp_valid_n, rsp_write_n;
    logic              init_busy_n, init_done_n;

    // Accept only from a quiet IDLE; a same-cycle init_start wins over the request.
    assign req_ready = (state == S_IDLE) && reset && !init_start;

    // Next-state and next-output logic; strobes and init_done default low so they pulse.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        addr_n      = addr;
        wdata_n     = wdata;
        wr_en_n     = 1'b0;
        rd_en_n     = 1'b0;
        rsp_valid_n = rsp_valid;
        rsp_write_n = rsp_write;
        rsp_addr_n  = rsp_addr;
        rsp_rdata_n = rsp_rdata;
        init_busy_n = init_busy;
        init_done_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (init_start) begin
                    init_busy_n = 1'b1;
                    cnt_n       = '0;
                    state_n     = S_INIT;
                end else if (req_valid) begin
                    addr_n      = req_addr;
                    wdata_n     = req_wdata;
                    wr_en_n     = req_write;
                    rd_en_n     = !req_write;
                    rsp_write_n = req_write;
                    rsp_addr_n  = req_addr;
                    state_n     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // The memory samples the strobe on this edge; writes need no data return.
                if (rsp_write) begin
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                    state_n     = S_RESP;
                end else begin
                    state_n     = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_rdata_n = rdata;
                rsp_valid_n = 1'b1;
                state_n     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            S_INIT: begin
                if (cnt == CNT_LAST) begin
                    init_busy_n = 1'b0;
                    init_done_n = 1'b1;
                    state_n     = S_IDLE;
                end else begin
                    addr_n  = cnt[ADDR_W-1:0];
                    wdata_n = INIT_VALUE;
                    wr_en_n = 1'b1;
                    cnt_n   = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction or init without a response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr      <= '0;
            wdata     <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            wr_en     <= wr_en_n;
            rd_en     <= rd_en_n;
            rsp_valid <= rsp_valid_n;
            rsp_write <= rsp_write_n;
            rsp_addr  <= rsp_addr_n;
            rsp_rdata <= rsp_rdata_n;
            init_busy <= init_busy_n;
            init_done <= init_done_n;
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - self-checking bench for mem_initiator with a registered-read memory model
module tb_mem_initiator;

    logic       clk;
    logic       reset;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_write;
    logic [2:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       init_start, init_busy, init_done;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       wr_en, rd_en;
    logic [7:0] rdata;

    mem_initiator #(.ADDR_W(3), .DATA_W(8), .DEPTH(8), .INIT_VALUE(8'hCA)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .addr(addr), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: power-up content 0xCA, one-cycle registered read, never reset.
    logic [7:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hCA;
        rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) rdata <= mem[addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
    } rsp_t;
    rsp_t sb[$];
    rsp_t exp_r;

    // Scoreboard: each handshaken response must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %0h/%0h/%0h, expected no response", rsp_write, rsp_addr, rsp_rdata);
            end else begin
                exp_r = sb.pop_front();
                chk("rsp", {rsp_write, rsp_addr, rsp_rdata}, {exp_r.w, exp_r.a, exp_r.d});
            end
        end
        if (wr_en && rd_en) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_overlap: got wr_en=1 rd_en=1, expected at most one");
        end
    end

    // Drive a request and wait (bounded) for acceptance; expected response pushed at acceptance.
    task automatic issue(input logic w, input logic [2:0] a, input logic [7:0] d, input logic [7:0] e);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back('{w, a, e});
                ok = 1'b1;
            end
        end
        chk("accepted", ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Strobe width and response latency after acceptance: write 1 cycle, read 2 cycles.
    task automatic post_accept(input logic w, input logic [2:0] a);
        @(negedge clk);
        chk("strobe_on", {wr_en, rd_en, addr, init_done, rsp_valid}, {w, !w, a, 1'b0, 1'b0});
        @(negedge clk);
        chk("strobe_off", {wr_en, rd_en}, 2'b00);
        if (w) begin
            chk("wr_latency", rsp_valid, 1'b1);
        end else begin
            chk("rd_not_early", rsp_valid, 1'b0);
            @(negedge clk);
            chk("rd_latency", rsp_valid, 1'b1);
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic w, input logic [2:0] a, input logic [7:0] d, input logic [7:0] e);
        issue(w, a, d, e);
        post_accept(w, a);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {addr, wdata, wr_en, rd_en, rsp_valid, rsp_write, rsp_addr, rsp_rdata, init_busy, init_done}, 64'd0);
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        bit         found;
        logic       exp_we;
        logic [2:0] ea;

        vecs[0] = '{1'b1, 3'd3, 8'h5A, 8'h00};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'h5A};
        vecs[2] = '{1'b0, 3'd7, 8'h00, 8'hCA};
        vecs[3] = '{1'b1, 3'd6, 8'h33, 8'h00};
        vecs[4] = '{1'b0, 3'd6, 8'h00, 8'h33};
        vecs[5] = '{1'b0, 3'd3, 8'h00, 8'h5A};

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; init_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_state");
        chk("reset_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;

        // Table-driven transactions
        for (int i = 0; i < 6; i++) xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);

        // Backpressure: response held 5 cycles, then handshake
        rsp_ready = 1'b0;
        xfer(1'b0, 3'd0, 8'h00, 8'hCA);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_stable", {rsp_valid, rsp_rdata, rsp_addr, req_ready}, {1'b1, 8'hCA, 3'd0, 1'b0});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_hs", {req_ready, rsp_valid}, 2'b10);
        @(posedge clk); #1;

        // Fill with 0x11, then init colliding with a read request
        for (int i = 0; i < 8; i++) xfer(1'b1, 3'(i), 8'h11, 8'h00);
        init_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2; req_wdata = 8'h00;
        @(negedge clk);
        chk("collide_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        init_start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_we = (n >= 2 && n <= 9);
            chk("init_wr_en", wr_en, exp_we);
            if (exp_we) begin
                ea = 3'(n - 2);
                chk("init_addr_data", {addr, wdata}, {ea, 8'hCA});
            end
            chk("init_busy_done", {init_busy, init_done}, (n == 10) ? 2'b01 : 2'b10);
            chk("init_req_ready", req_ready, n == 10);
            if (n == 10) sb.push_back('{1'b0, 3'd2, 8'hCA});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        post_accept(1'b0, 3'd2);
        for (int i = 0; i < 8; i++) xfer(1'b0, 3'(i), 8'h00, 8'hCA);

        // init_start during a read is ignored
        issue(1'b0, 3'd5, 8'h00, 8'hCA);
        init_start = 1'b1;
        @(negedge clk);
        chk("rd_init_strobe", {wr_en, rd_en, addr}, {1'b0, 1'b1, 3'd5});
        @(posedge clk); #1;
        init_start = 1'b0;
        @(negedge clk);
        chk("rd_init_ignored", {init_busy, wr_en, rd_en, rsp_valid}, 4'b0000);
        @(negedge clk);
        chk("rd_init_rsp", {rsp_valid, init_busy}, 2'b10);
        @(posedge clk); #1;

        // Reset while in CAPTURE
        issue(1'b0, 3'd1, 8'h00, 8'hCA);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_reset_outputs("rst_capture_outputs");
        chk("rst_capture_ready", req_ready, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_capture_no_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;

        // Reset during init at counter 4
        for (int i = 0; i < 8; i++) xfer(1'b1, 3'(i), 8'h11, 8'h00);
        init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wr_en && addr == 3'd3) found = 1'b1;
        end
        chk("init_reached_4", found, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_init_outputs");
        @(negedge clk);
        chk("rst_init_no_done", {init_done, wr_en, init_busy}, 3'b000);
        @(posedge clk); #1;
        xfer(1'b0, 3'd5, 8'h00, 8'h11);
        xfer(1'b0, 3'd6, 8'h00, 8'h11);
        xfer(1'b0, 3'd7, 8'h00, 8'h11);
        xfer(1'b0, 3'd0, 8'h00, 8'hCA);
        xfer(1'b0, 3'd3, 8'h00, 8'hCA);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
